// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the five-source bus arbiter
package bus_pkg;
    localparam int NREQ  = 5;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    typedef logic [NREQ-1:0] req_vec_t;
endpackage

// File: rtl/rr_pick5.sv
// rtl/rr_pick5.sv - combinational round-robin picker: first set candidate from ptr, cyclic mod 5
module rr_pick5
    import bus_pkg::*;
(
    input  req_vec_t         i_cand,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_found,
    output logic [SEL_W-1:0] o_index,
    output req_vec_t         o_onehot
);

    logic [SEL_W:0] w_idx;

    // Scan ptr, ptr+1, ... wrapping at NREQ; the earliest hit in that order wins.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, i_ptr} + (SEL_W+1)'(k);
            if (w_idx >= (SEL_W+1)'(NREQ)) begin
                w_idx = w_idx - (SEL_W+1)'(NREQ);
            end
            if (!o_found && i_cand[w_idx[SEL_W-1:0]]) begin
                o_found = 1'b1;
                o_index = w_idx[SEL_W-1:0];
            end
        end
    end

    assign o_onehot = o_found ? (req_vec_t'(1) << o_index) : '0;

endmodule

// File: rtl/bus_arbiter5.sv
// rtl/bus_arbiter5.sv - round-robin owner of the 5:1 data bus select with bounded hold preemption
module bus_arbiter5
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [4:0]                    req,
    output logic [4:0]                    grant,
    output logic [2:0]                    sel,
    output logic                          bus_busy,
    output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt
);

    localparam int            HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_t       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_owner;
    req_vec_t         r_grant;
    logic [HW-1:0]    r_hold;

    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] w_owner_nxt;
    req_vec_t         w_grant_nxt;
    logic [HW-1:0]    w_hold_nxt;

    req_vec_t         w_others;
    logic             w_owner_req;
    logic             w_preempt;
    logic             w_release;
    logic [SEL_W-1:0] w_ptr_rel;
    req_vec_t         w_pick_cand;
    logic [SEL_W-1:0] w_pick_ptr;
    logic             w_found;
    logic [SEL_W-1:0] w_pick_idx;
    req_vec_t         w_pick_onehot;

    assign w_others    = req & ~(req_vec_t'(1) << r_owner);
    assign w_owner_req = req[r_owner];
    assign w_preempt   = (r_hold == HOLD_MAX) && (|w_others);
    assign w_release   = (r_state == OWN) && (!w_owner_req || w_preempt);
    assign w_ptr_rel   = (r_owner == SEL_W'(NREQ - 1)) ? '0 : r_owner + SEL_W'(1);

    // One picker serves both arbitration cases: fresh pick from IDLE, or handoff
    // among the non-owners starting just past the releasing owner.
    assign w_pick_cand = (r_state == IDLE) ? req : w_others;
    assign w_pick_ptr  = (r_state == IDLE) ? r_ptr : w_ptr_rel;

    rr_pick5 u_pick (
        .i_cand   (w_pick_cand),
        .i_ptr    (w_pick_ptr),
        .o_found  (w_found),
        .o_index  (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_grant <= w_grant_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_grant_nxt = r_grant;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = OWN;
                    w_owner_nxt = w_pick_idx;
                    w_grant_nxt = w_pick_onehot;
                    w_hold_nxt  = HW'(1);
                end
            end
            OWN: begin
                if (w_release) begin
                    w_ptr_nxt = w_ptr_rel;
                    if (w_found) begin
                        w_owner_nxt = w_pick_idx;
                        w_grant_nxt = w_pick_onehot;
                        w_hold_nxt  = HW'(1);
                    end else begin
                        // Owner index is kept so the mux select stays put while idle.
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_hold != HOLD_MAX) begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign grant    = r_grant;
    assign sel      = r_owner;
    assign bus_busy = |r_grant;
    assign hold_cnt = r_hold;

endmodule

// File: tb/tb_bus_arbiter5.sv
// tb/tb_bus_arbiter5.sv - randomized and directed self-checking bench for bus_arbiter5
module tb_bus_arbiter5;

    localparam int MH = 8;
    localparam int HW = $clog2(MH + 1);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [4:0]    req = '0;
    logic [4:0]    grant;
    logic [2:0]    sel;
    logic          bus_busy;
    logic [HW-1:0] hold_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit en_cmp   = 1'b0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_sel   = 0;

    bus_arbiter5 #(.MAX_HOLD(MH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .bus_busy (bus_busy),
        .hold_cnt (hold_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic [4:0] c, input int p);
        for (int k = 0; k < 5; k++) begin
            if (c[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    // Reference model: owner as an integer, -1 when the bus is free.
    always @(posedge Clk) begin
        logic [4:0] others;
        int o;
        if (Reset) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            o = m_pick(req, m_ptr);
            if (o >= 0) begin
                m_owner = o; m_sel = o; m_hold = 1;
            end
        end else begin
            others = req & ~(5'b1 << m_owner);
            if (!req[m_owner] || (m_hold == MH && others != 0)) begin
                m_ptr = (m_owner + 1) % 5;
                o = m_pick(others, m_ptr);
                if (o >= 0) begin
                    m_owner = o; m_sel = o; m_hold = 1;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else if (m_hold < MH) begin
                m_hold = m_hold + 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (en_cmp) begin
            chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
            chk("sel", sel, m_sel);
            chk("bus_busy", bus_busy, (m_owner >= 0) ? 1 : 0);
            chk("hold_cnt", hold_cnt, m_hold);
            chk("grant_onehot0", $onehot0(grant) ? 1 : 0, 1);
            chk("sel_range", (sel < 3'd5) ? 1 : 0, 1);
        end
    end

    task automatic tick(input logic [4:0] r, input logic rst);
        req   = r;
        Reset = rst;
        @(negedge Clk);
        #1;
    endtask

    initial begin
        logic [4:0] rr;
        @(negedge Clk); #1;
        tick(5'b00000, 1'b1);
        en_cmp = 1'b1;
        tick(5'b00000, 1'b1);
        chk("rst_grant", grant, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", bus_busy, 0);
        chk("rst_hold", hold_cnt, 0);

        // single requester: hold saturates at MH
        tick(5'b00100, 1'b0);
        chk("single_grant", grant, 5'b00100);
        chk("single_sel", sel, 2);
        chk("single_busy", bus_busy, 1);
        for (int k = 2; k <= 11; k++) begin
            tick(5'b00100, 1'b0);
            chk("single_hold", hold_cnt, (k < MH) ? k : MH);
        end
        tick(5'b00000, 1'b0);
        chk("idle_grant", grant, 0);
        chk("idle_busy", bus_busy, 0);
        chk("idle_hold", hold_cnt, 0);
        chk("idle_sel_kept", sel, 2);

        // simultaneous requests, handoffs, wrap
        tick(5'b00000, 1'b1);
        tick(5'b10110, 1'b0);
        chk("multi_first", grant, 5'b00010);
        tick(5'b10100, 1'b0);
        chk("handoff_2", grant, 5'b00100);
        chk("handoff_2_hold", hold_cnt, 1);
        tick(5'b10000, 1'b0);
        chk("handoff_4", grant, 5'b10000);
        chk("handoff_4_sel", sel, 4);
        tick(5'b00011, 1'b0);
        chk("wrap_to_0", grant, 5'b00001);
        tick(5'b00000, 1'b0);

        // preemption after exactly MH cycles
        tick(5'b00000, 1'b1);
        tick(5'b00001, 1'b0);
        tick(5'b00001, 1'b0);
        tick(5'b00001, 1'b0);
        chk("pre_hold3", hold_cnt, 3);
        for (int k = 4; k <= MH; k++) begin
            tick(5'b01001, 1'b0);
            chk("pre_still0", grant, 5'b00001);
        end
        chk("pre_hold_max", hold_cnt, MH);
        tick(5'b01001, 1'b0);
        chk("pre_to3", grant, 5'b01000);
        chk("pre_to3_hold", hold_cnt, 1);
        tick(5'b01001, 1'b0);
        tick(5'b01001, 1'b0);
        chk("pre_3_kept", grant, 5'b01000);
        tick(5'b00001, 1'b0);
        chk("pre_back0", grant, 5'b00001);

        // reset while owned
        tick(5'b00000, 1'b1);
        tick(5'b01000, 1'b0);
        chk("mid_own3", grant, 5'b01000);
        tick(5'b01000, 1'b1);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_hold", hold_cnt, 0);
        tick(5'b01000, 1'b0);
        chk("mid_regrant", grant, 5'b01000);

        // randomized traffic, model-checked every cycle
        rr = 5'b00000;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            end
            tick(rr, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        en_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter5.md
# bus_arbiter5

- Round-robin arbiter that shares the final project's 16-bit, five-source data bus between five requesters.
- Owns the 3-bit select of the 5:1 16-bit bus multiplexer (inputs 0..4), so exactly one source drives the bus at a time.
- Grants are registered, held while the owner keeps requesting, and preempted after a bounded hold if other requests are pending.
- Sits between the requesting units (CPU, sprite/video fetch, peripherals) and the bus mux select.

## Interface
Parameters:
- MAX_HOLD, default 8: maximum consecutive granted cycles per owner before preemption when others wait. Legal range ≥ 1.
- NREQ, fixed 5: number of requesters. Not overridable; matches the mux input count.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  [4:0]  request per source. Held high for as long as the source wants the bus.
- grant  output  [4:0]  one-hot grant, registered. All zero when idle.
- sel  output  [2:0]  binary index of current owner, drives the mux select. Only values 0..4.
- bus_busy  output  1  high while any grant bit is high; equals OR of grant.
- hold_cnt  output  [$clog2(MAX_HOLD+1)-1:0]  cycles the current owner has held the bus.

## Operation
- Reset values: grant=5'b00000, sel=3'b000, bus_busy=0, hold_cnt=0, rotation pointer ptr=0, state IDLE.
- States: IDLE (no owner) and OWN (owner o holds the bus).
- Pick function: first set bit of a candidate vector in cyclic order ptr, ptr+1, … mod 5.

IDLE:
- If req≠0: pick o from req, grant[o]=1, sel=o, hold_cnt=1, go to OWN.
- Else: stay in IDLE; sel holds its last value.

OWN, release condition R = !req[o] OR (hold_cnt==MAX_HOLD AND (req & ~(1<<o))≠0):
- !R: stay; hold_cnt increments, saturating at MAX_HOLD.
- R: ptr ← (o+1) mod 5. Pick the next owner from req & ~(1<<o), using the updated ptr.
  - If a requester is found: direct handoff on the same edge. New grant/sel, hold_cnt=1, stay in OWN, no dead cycle.
  - If none is found: go to IDLE, grant=0, hold_cnt=0.
- A preempted owner that still requests becomes a normal candidate at lowest priority. It does not re-acquire until the others in rotation are served.
- With only one requester active, preemption never fires. That requester holds the bus indefinitely; hold_cnt saturates.
- Multiple simultaneous new requests resolve in rotation order from ptr. Ties are impossible.
- grant is always one-hot or zero. sel never takes values 5–7.

## Timing
- Latency from req rising to grant: 1 cycle. req seen at edge t gives grant visible after edge t.
- Release latency: req[o] low during cycle t gives grant[o] low after edge t+1. The owner must not depend on the bus in the cycle it drops req.
- Handoff: old grant falls and new grant rises on the same edge. sel changes on that edge. Bus data is valid for the new owner in the following cycle.
- Preemption: the owner receives exactly MAX_HOLD granted cycles when others wait.
- Reset asserted mid-grant: all outputs return to reset values at the next edge regardless of req. Arbitration resumes the cycle after Reset deasserts.

## Structure
- Shared package (bus_pkg):
  - NREQ = 5.
  - SEL_W = 3.
  - Typedef arb_state_t {IDLE, OWN}.
  - Typedef req_vec_t = logic [NREQ-1:0].
- Sub-module rr_pick5 (combinational):
  - Inputs: candidate vector [4:0], ptr [2:0].
  - Outputs: found, index [2:0], one-hot [4:0].
  - Used for both the IDLE pick and the handoff pick.
- Top level holds state, ptr, owner, hold_cnt registers and the release logic.

## Test plan
- Reset then single request: req=5'b00100 from cycle 2 → grant=5'b00100, sel=2, bus_busy=1 after next edge. hold_cnt counts 1,2,…,8 and stays at 8.
- Simultaneous requests after reset (ptr=0): req=5'b10110 → owner 1. Drop req[1] → handoff to 2 with no idle cycle. Drop req[2] → handoff to 4.
- Preemption (MAX_HOLD=8): requester 0 holds, requester 3 raises req at hold_cnt=3 → grant moves to 3 after exactly 8 granted cycles of 0. Requester 0 still requesting is regranted only after 3 releases.
- Rotation wrap: owner 4 releases while req=5'b00011 → ptr=0, grant to 0 (not 1).
- Release to idle: sole owner drops req → grant=0, bus_busy=0, hold_cnt=0 after one edge. sel keeps its last value.
- Reset mid-ownership: Reset high for one cycle while grant=5'b01000, req still set → outputs at reset values after that edge. Owner 3 regranted one cycle after Reset low (ptr=0, only req[3] set).
